mem_wb_stage: RTL and testbench

//  EX->MEM->WB stage control. Latches EX results (writedata_EX, wrt_dmem load flag, store, rd) into M regs.

---
 rtl/mem_wb_stage_pkg.sv | 11 +
 rtl/mem_wb_stage_if.sv | 22 ++
 rtl/mem_wb_stage_timer.sv | 21 ++
 rtl/mem_wb_stage.sv | 148 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared widths and FSM encoding for the MEM/WB stage.
// Optional misaligned-access trap: define MEM_ALIGN_CHK_EN.
package mem_wb_stage_pkg;
  localparam int DATA_W  = 16;
  localparam int RADDR_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-cache request/done bus: the stage is master, the cache is slave.
// Handshake: dmem_req is a level held with wr/addr/wdata stable until dmem_done; rdata is valid with done.
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_wr;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_done;

  modport master (
    output dmem_req, dmem_wr, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_done
  );

  modport slave (
    input  dmem_req, dmem_wr, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_done
  );
endinterface

// File: rtl/mem_wb_stage_timer.sv
// Wait-cycle counter for outstanding cache requests; o_expire flags TIMEOUT_CYC reached.
module mem_wait_timer #(
  parameter  int TIMEOUT_CYC = 64,
  localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = (r_cnt == CNT_W'(TIMEOUT_CYC));
endmodule

// File: rtl/mem_wb_stage.sv
// EX->M->WB stage: latches EX results, runs the dcache req/done handshake, registers write-back.
// Optional misaligned-address trap enabled with `define MEM_ALIGN_CHK_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ex_valid,
  input  logic [DATA_W-1:0]  i_ex_wdata,
  input  logic               i_ex_load,
  input  logic               i_ex_store,
  input  logic [DATA_W-1:0]  i_ex_addr,
  input  logic [DATA_W-1:0]  i_ex_st_data,
  input  logic [RADDR_W-1:0] i_ex_rd,
  input  logic               i_ex_regwrite,
  input  logic               i_flush,
  mem_wb_stage_if.master     dmem,
  output logic               o_stall,
  output logic               o_wb_valid,
  output logic               o_wb_regwrite,
  output logic [RADDR_W-1:0] o_wb_rd,
  output logic [DATA_W-1:0]  o_wb_data,
  output logic               o_mem_err,
  output state_t             o_state
);
  logic               r_m_valid, r_m_load, r_m_store, r_m_regwrite;
  logic [DATA_W-1:0]  r_m_wdata, r_m_addr, r_m_st_data;
  logic [RADDR_W-1:0] r_m_rd;
  logic               r_wb_valid, r_wb_regwrite, r_mem_err;
  logic [RADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0]  r_wb_data;
  state_t             r_state, w_state_nxt;
  logic               w_mop, w_st_eff, w_misalign, w_to_abort, w_abort, w_req;
  logic               w_tmr_clr, w_tmr_inc, w_expire;

  assign w_mop    = r_m_valid & (r_m_load | r_m_store);
  // Load wins when both flags are set.
  assign w_st_eff = r_m_store & ~r_m_load;

`ifdef MEM_ALIGN_CHK_EN
  assign w_misalign = w_mop & r_m_addr[0];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_to_abort = (r_state == ST_WAIT) & w_expire & ~dmem.dmem_done;
  assign w_abort    = w_misalign | w_to_abort;
  assign w_req      = w_mop & ~w_abort;
  assign o_stall    = w_mop & ~dmem.dmem_done & ~w_abort;

  assign dmem.dmem_req   = w_req;
  assign dmem.dmem_wr    = w_st_eff;
  assign dmem.dmem_addr  = r_m_addr;
  assign dmem.dmem_wdata = r_m_st_data;

  mem_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmr_clr),
    .i_inc    (w_tmr_inc),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_clr   = 1'b0;
    w_tmr_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && !dmem.dmem_done) begin
          w_state_nxt = ST_WAIT;
          w_tmr_inc   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem.dmem_done || w_to_abort) begin
          w_state_nxt = ST_IDLE;
          w_tmr_clr   = 1'b1;
        end else begin
          w_tmr_inc   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tmr_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // M regs hold while the stage waits on the cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid    <= 1'b0;
      r_m_load     <= 1'b0;
      r_m_store    <= 1'b0;
      r_m_regwrite <= 1'b0;
      r_m_wdata    <= '0;
      r_m_addr     <= '0;
      r_m_st_data  <= '0;
      r_m_rd       <= '0;
    end else if (!o_stall) begin
      r_m_valid    <= i_ex_valid & ~i_flush;
      r_m_load     <= i_ex_load;
      r_m_store    <= i_ex_store;
      r_m_regwrite <= i_ex_regwrite;
      r_m_wdata    <= i_ex_wdata;
      r_m_addr     <= i_ex_addr;
      r_m_st_data  <= i_ex_st_data;
      r_m_rd       <= i_ex_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid    <= 1'b0;
      r_wb_regwrite <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_data     <= '0;
    end else if (o_stall) begin
      r_wb_valid    <= 1'b0;
      r_wb_regwrite <= 1'b0;
    end else begin
      r_wb_valid    <= r_m_valid;
      r_wb_rd       <= r_m_rd;
      r_wb_regwrite <= r_m_valid & r_m_regwrite & ~w_st_eff;
      r_wb_data     <= r_m_load ? (w_abort ? '0 : dmem.dmem_rdata) : r_m_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_mem_err <= 1'b0;
    else if (w_abort) r_mem_err <= 1'b1;
  end

  assign o_wb_valid    = r_wb_valid;
  assign o_wb_regwrite = r_wb_regwrite;
  assign o_wb_rd       = r_wb_rd;
  assign o_wb_data     = r_wb_data;
  assign o_mem_err     = r_mem_err;
  assign o_state       = r_state;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for the ALU path plus hand sequences for memory ops.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int TO = 4;
  localparam int EW = 21;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               ex_valid, ex_load, ex_store, ex_regwrite, flush;
  logic [DATA_W-1:0]  ex_wdata, ex_addr, ex_st_data;
  logic [RADDR_W-1:0] ex_rd;
  logic               stall, wb_valid, wb_regwrite, mem_err;
  logic [RADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]  wb_data;
  state_t             state;

  mem_wb_stage_if dmem_bus();

  mem_wb_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_ex_valid    (ex_valid),
    .i_ex_wdata    (ex_wdata),
    .i_ex_load     (ex_load),
    .i_ex_store    (ex_store),
    .i_ex_addr     (ex_addr),
    .i_ex_st_data  (ex_st_data),
    .i_ex_rd       (ex_rd),
    .i_ex_regwrite (ex_regwrite),
    .i_flush       (flush),
    .dmem          (dmem_bus.master),
    .o_stall       (stall),
    .o_wb_valid    (wb_valid),
    .o_wb_regwrite (wb_regwrite),
    .o_wb_rd       (wb_rd),
    .o_wb_data     (wb_data),
    .o_mem_err     (mem_err),
    .o_state       (state)
  );

  typedef struct {
    logic               v;
    logic [DATA_W-1:0]  wd;
    logic [RADDR_W-1:0] rd;
    logic               rw;
    logic               fl;
    logic               e_v;
    logic               e_rw;
    logic [RADDR_W-1:0] e_rd;
    logic [DATA_W-1:0]  e_data;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl[NV];
  logic [EW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic ex_idle();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_regwrite = 1'b0; flush = 1'b0;
    ex_wdata = '0; ex_addr = '0; ex_st_data = '0; ex_rd = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_mem(input logic ld, input logic st, input logic [15:0] addr,
                           input logic [15:0] sd, input logic [2:0] rd, input logic rw);
    ex_idle();
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_addr = addr;
    ex_st_data = sd; ex_rd = rd; ex_regwrite = rw;
  endtask

  initial begin
    logic [EW-1:0] e;

    tbl[0] = '{1'b1, 16'h1234, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 16'h1234};
    tbl[1] = '{1'b1, 16'h0055, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 16'h0055};
    tbl[2] = '{1'b1, 16'hFFFF, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000};
    tbl[3] = '{1'b0, 16'hABCD, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000};
    tbl[4] = '{1'b1, 16'h8001, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 16'h8001};
    tbl[5] = '{1'b1, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000};

    rst = 1'b1;
    ex_idle();
    dmem_bus.dmem_done  = 1'b0;
    dmem_bus.dmem_rdata = '0;
    #2;
    chk("rst_req",      dmem_bus.dmem_req,  0);
    chk("rst_addr",     dmem_bus.dmem_addr, 0);
    chk("rst_stall",    stall,              0);
    chk("rst_wb_valid", wb_valid,           0);
    chk("rst_wb_data",  wb_data,            0);
    chk("rst_mem_err",  mem_err,            0);
    chk("rst_state",    state,              ST_IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ALU path table: result visible two edges after drive
    for (int i = 0; i < NV + 2; i++) begin
      next_cyc();
      ex_idle();
      if (i < NV) begin
        ex_valid = tbl[i].v; ex_wdata = tbl[i].wd; ex_rd = tbl[i].rd;
        ex_regwrite = tbl[i].rw; flush = tbl[i].fl;
        exp_q.push_back({tbl[i].e_v, tbl[i].e_rw, tbl[i].e_rd, tbl[i].e_data});
      end
      sample();
      chk("alu_stall", stall, 0);
      if (i >= 2) begin
        e = exp_q.pop_front();
        chk("alu_wb_valid", wb_valid,    e[20]);
        chk("alu_wb_rw",    wb_regwrite, e[19]);
        if (e[20]) begin
          chk("alu_wb_rd",   wb_rd,   e[18:16]);
          chk("alu_wb_data", wb_data, e[15:0]);
        end
      end
    end

    // load hit: done in the issue cycle
    next_cyc(); drive_mem(1'b1, 1'b0, 16'h0040, 16'h0, 3'd5, 1'b1);
    next_cyc(); ex_idle(); dmem_bus.dmem_done = 1'b1; dmem_bus.dmem_rdata = 16'hBEEF;
    sample();
    chk("hit_req",   dmem_bus.dmem_req,  1);
    chk("hit_addr",  dmem_bus.dmem_addr, 16'h0040);
    chk("hit_wr",    dmem_bus.dmem_wr,   0);
    chk("hit_stall", stall,              0);
    next_cyc(); dmem_bus.dmem_done = 1'b0;
    sample();
    chk("hit_wb_valid", wb_valid,    1);
    chk("hit_wb_data",  wb_data,     16'hBEEF);
    chk("hit_wb_rd",    wb_rd,       5);
    chk("hit_wb_rw",    wb_regwrite, 1);

    // load miss: done on the fourth WAIT cycle (counter at TIMEOUT, done wins)
    next_cyc(); drive_mem(1'b1, 1'b0, 16'h0080, 16'h0, 3'd2, 1'b1);
    next_cyc(); ex_idle(); dmem_bus.dmem_rdata = 16'h0BAD;
    sample();
    chk("miss_issue_stall", stall,             1);
    chk("miss_issue_req",   dmem_bus.dmem_req, 1);
    for (int k = 1; k <= 3; k++) begin
      next_cyc();
      sample();
      chk("miss_wait_stall", stall,              1);
      chk("miss_wait_req",   dmem_bus.dmem_req,  1);
      chk("miss_wait_addr",  dmem_bus.dmem_addr, 16'h0080);
      chk("miss_wait_state", state,              ST_WAIT);
      chk("miss_bubble",     wb_valid,           0);
    end
    next_cyc(); dmem_bus.dmem_done = 1'b1; dmem_bus.dmem_rdata = 16'h1357;
    sample();
    chk("miss_done_stall", stall,    0);
    chk("miss_last_bubble", wb_valid, 0);
    next_cyc(); dmem_bus.dmem_done = 1'b0;
    sample();
    chk("miss_wb_valid", wb_valid, 1);
    chk("miss_wb_data",  wb_data,  16'h1357);
    chk("miss_wb_rd",    wb_rd,    2);
    chk("miss_state",    state,    ST_IDLE);

    // store hit
    next_cyc(); drive_mem(1'b0, 1'b1, 16'h0010, 16'hA5A5, 3'd6, 1'b1);
    next_cyc(); ex_idle(); dmem_bus.dmem_done = 1'b1;
    sample();
    chk("st_req",   dmem_bus.dmem_req,   1);
    chk("st_wr",    dmem_bus.dmem_wr,    1);
    chk("st_wdata", dmem_bus.dmem_wdata, 16'hA5A5);
    chk("st_addr",  dmem_bus.dmem_addr,  16'h0010);
    next_cyc(); dmem_bus.dmem_done = 1'b0;
    sample();
    chk("st_wb_valid", wb_valid,    1);
    chk("st_wb_rw",    wb_regwrite, 0);
    chk("st_no_err",   mem_err,     0);

    // load+store together behaves as a load
    next_cyc(); drive_mem(1'b1, 1'b1, 16'h0012, 16'h7777, 3'd1, 1'b1);
    next_cyc(); ex_idle(); dmem_bus.dmem_done = 1'b1; dmem_bus.dmem_rdata = 16'h4242;
    sample();
    chk("ldst_wr", dmem_bus.dmem_wr, 0);
    next_cyc(); dmem_bus.dmem_done = 1'b0;
    sample();
    chk("ldst_wb_data", wb_data,     16'h4242);
    chk("ldst_wb_rw",   wb_regwrite, 1);

    // timeout: no done ever
    next_cyc(); drive_mem(1'b1, 1'b0, 16'h0020, 16'h0, 3'd4, 1'b1);
    next_cyc(); ex_idle(); dmem_bus.dmem_rdata = 16'hFFFF;
    sample();
    chk("to_issue_req", dmem_bus.dmem_req, 1);
    for (int k = 1; k <= 3; k++) begin
      next_cyc();
      sample();
      chk("to_wait_stall", stall,             1);
      chk("to_wait_req",   dmem_bus.dmem_req, 1);
    end
    next_cyc();
    sample();
    chk("to_abort_req",   dmem_bus.dmem_req, 0);
    chk("to_abort_stall", stall,             0);
    chk("to_err_late",    mem_err,           0);
    next_cyc(); ex_idle(); ex_valid = 1'b1; ex_wdata = 16'h0F0F; ex_rd = 3'd1; ex_regwrite = 1'b1;
    sample();
    chk("to_mem_err",  mem_err,  1);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_data",  wb_data,  16'h0000);
    chk("to_state",    state,    ST_IDLE);
    next_cyc(); ex_idle();
    next_cyc();
    sample();
    chk("resume_wb_data", wb_data,  16'h0F0F);
    chk("resume_wb_valid", wb_valid, 1);
    chk("resume_stall",   stall,    0);

    // reset pulse while waiting
    next_cyc(); drive_mem(1'b1, 1'b0, 16'h0030, 16'h0, 3'd3, 1'b1);
    next_cyc(); ex_idle();
    next_cyc();
    next_cyc();
    sample();
    chk("rw_pre_state", state,             ST_WAIT);
    chk("rw_pre_req",   dmem_bus.dmem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rw_req",      dmem_bus.dmem_req,  0);
    chk("rw_addr",     dmem_bus.dmem_addr, 0);
    chk("rw_stall",    stall,              0);
    chk("rw_state",    state,              ST_IDLE);
    chk("rw_wb_valid", wb_valid,           0);
    chk("rw_wb_data",  wb_data,            0);
    chk("rw_mem_err",  mem_err,            0);
    @(negedge clk);
    rst = 1'b0;

    // misaligned load
    next_cyc(); drive_mem(1'b1, 1'b0, 16'h0041, 16'h0, 3'd7, 1'b1);
    next_cyc(); ex_idle(); dmem_bus.dmem_rdata = 16'h2468;
`ifdef MEM_ALIGN_CHK_EN
    sample();
    chk("mis_req",   dmem_bus.dmem_req, 0);
    chk("mis_stall", stall,             0);
    next_cyc();
    sample();
    chk("mis_mem_err",  mem_err,  1);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_data",  wb_data,  16'h0000);
`else
    dmem_bus.dmem_done = 1'b1;
    sample();
    chk("mis_req",  dmem_bus.dmem_req,  1);
    chk("mis_addr", dmem_bus.dmem_addr, 16'h0041);
    next_cyc(); dmem_bus.dmem_done = 1'b0;
    sample();
    chk("mis_mem_err", mem_err, 0);
    chk("mis_wb_data", wb_data, 16'h2468);
`endif

    // done outside a request must not disturb anything
    next_cyc(); dmem_bus.dmem_done = 1'b1;
    sample();
    chk("stray_req",   dmem_bus.dmem_req, 0);
    chk("stray_state", state,             ST_IDLE);
    next_cyc(); dmem_bus.dmem_done = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
